// File: rtl/z_altitude_filter.sv
// z_altitude_filter
//   Turns raw rangefinder distances into a clean altitude stream for the
//   z_linear_velocity_comp stage, which is triggered by start_signal.
//   Samples outside [MIN_RANGE_MM, MAX_RANGE_MM] are dropped. Once primed,
//   a sample that is more than MAX_STEP_MM away from the current output is
//   dropped as a spike. After MAX_REJECTS consecutive spike rejections, the
//   next in-range sample is taken as the new truth and re-primes the
//   average. Accepted samples feed a 2^AVG_LOG2-deep moving average.
//
// Ports
//   us_clk         system clock
//   reset          asynchronous, active-high reset
//   raw_range_mm   unsigned raw distance (mm), qualified by raw_valid
//   raw_valid      one-cycle strobe; only honoured while the FSM is in WAIT
//   z_altitude_mm  filtered altitude (mm), non-negative, updated on EMIT entry
//   start_signal   one-cycle pulse while in EMIT; z_altitude_mm is fresh
//   outlier_count  total rejected samples, saturating at 255
//   primed         high once the first valid sample has been accepted
//
// Handshake: raw_valid is a one-cycle strobe with no ready. It is consumed
//   only in WAIT; a strobe in any other state is dropped with no side effect.
//   Accepted sample in cycle N -> start_signal in cycle N+4. A rejected
//   sample is back in WAIT at N+2.
//
// Constraints: AVG_LOG2 >= 1; MAX_RANGE_MM < 2^(WIDTH-1).

module z_altitude_filter #(
  parameter int WIDTH        = 16,
  parameter int AVG_LOG2     = 2,
  parameter int MIN_RANGE_MM = 1,
  parameter int MAX_RANGE_MM = 10000,
  parameter int MAX_STEP_MM  = 500,
  parameter int MAX_REJECTS  = 3
) (
  input  logic                    us_clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        raw_range_mm,
  input  logic                    raw_valid,
  output logic signed [WIDTH-1:0] z_altitude_mm,
  output logic                    start_signal,
  output logic [7:0]              outlier_count,
  output logic                    primed
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = WIDTH + AVG_LOG2;
  localparam int RW    = $clog2(MAX_REJECTS + 2);

  localparam logic [WIDTH-1:0] MIN_L  = WIDTH'(MIN_RANGE_MM);
  localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX_RANGE_MM);
  localparam logic [WIDTH:0]   STEP_L = (WIDTH+1)'(MAX_STEP_MM);
  localparam logic [RW-1:0]    REJ_L  = RW'(MAX_REJECTS);

  typedef enum logic [4:0] {
    WAIT    = 5'b00001,
    CHECK   = 5'b00010,
    UPDATE  = 5'b00100,
    AVERAGE = 5'b01000,
    EMIT    = 5'b10000
  } state_t;

  // state is the FSM observation point for checkers.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]    sample_latched;
  logic [WIDTH-1:0]    buffer [DEPTH];
  logic [SW-1:0]       sum;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [RW-1:0]       reject_run;
  logic                reprime;

  // CHECK-state decode
  logic                sample_invalid;
  logic                need_reprime;
  logic signed [WIDTH:0] step_diff;
  logic [WIDTH:0]      step_abs;
  logic                step_too_big;
  logic [SW-1:0]       avg_full;

  always_comb begin
    sample_invalid = (sample_latched < MIN_L) || (sample_latched > MAX_L);
    need_reprime   = !primed || (reject_run == REJ_L);
    // Both operands are < 2^(WIDTH-1), so WIDTH+1 signed bits cannot overflow.
    step_diff      = $signed({1'b0, sample_latched}) - $signed({1'b0, z_altitude_mm});
    step_abs       = step_diff[WIDTH] ? (WIDTH+1)'(-step_diff) : (WIDTH+1)'(step_diff);
    step_too_big   = step_abs > STEP_L;
    avg_full       = sum >> AVG_LOG2;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT: begin
        if (raw_valid) state_next = CHECK;
      end
      CHECK: begin
        if (sample_invalid)    state_next = WAIT;
        else if (need_reprime) state_next = UPDATE;
        else if (step_too_big) state_next = WAIT;
        else                   state_next = UPDATE;
      end
      UPDATE:  state_next = AVERAGE;
      AVERAGE: state_next = EMIT;
      EMIT:    state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  assign start_signal = (state == EMIT);

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state          <= WAIT;
      sample_latched <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
      sum            <= '0;
      wr_ptr         <= '0;
      reject_run     <= '0;
      reprime        <= 1'b0;
      z_altitude_mm  <= '0;
      outlier_count  <= '0;
      primed         <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        WAIT: begin
          if (raw_valid) sample_latched <= raw_range_mm;
        end
        CHECK: begin
          if (sample_invalid) begin
            // Out-of-range samples do not count toward the re-prime run.
            if (outlier_count != 8'hFF) outlier_count <= outlier_count + 8'd1;
          end else if (need_reprime) begin
            reprime    <= 1'b1;
            reject_run <= '0;
          end else if (step_too_big) begin
            if (outlier_count != 8'hFF) outlier_count <= outlier_count + 8'd1;
            // Cannot pass REJ_L: reaching it forces the re-prime branch next time.
            reject_run <= reject_run + 1'b1;
          end else begin
            reprime    <= 1'b0;
            reject_run <= '0;
          end
        end
        UPDATE: begin
          if (reprime) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= sample_latched;
            sum     <= SW'(sample_latched) << AVG_LOG2;
            wr_ptr  <= '0;
            primed  <= 1'b1;
            reprime <= 1'b0;
          end else begin
            sum            <= sum - SW'(buffer[wr_ptr]) + SW'(sample_latched);
            buffer[wr_ptr] <= sample_latched;
            wr_ptr         <= wr_ptr + 1'b1;
          end
        end
        AVERAGE: begin
          // Average of in-range samples always fits in WIDTH-1 bits.
          z_altitude_mm <= avg_full[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/z_altitude_filter.md
Name: z_altitude_filter

Overview:
Conditions raw rangefinder distance samples into a clean altitude stream for z_linear_velocity_comp, which sits directly downstream. Out-of-range samples and single-sample spikes are rejected. Accepted samples go through a power-of-two moving average. Each new average is presented on z_altitude_mm with a one-cycle start_signal pulse, which matches the WAIT-state trigger of the velocity stage.

Parameters:
WIDTH, 16, width of range input and altitude output (matches RATE_BIT_WIDTH)
AVG_LOG2, 2, log2 of moving-average depth (default depth 4)
MIN_RANGE_MM, 1, smallest valid raw sample
MAX_RANGE_MM, 10000, largest valid raw sample; must be < 2^(WIDTH-1)
MAX_STEP_MM, 500, largest accepted |sample - current output| once primed
MAX_REJECTS, 3, consecutive step rejections tolerated before a forced re-prime

Ports:
us_clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
raw_range_mm  input  WIDTH  unsigned raw distance in mm
raw_valid  input  1  one-cycle strobe; raw_range_mm is valid this cycle
z_altitude_mm  output  WIDTH  signed filtered altitude in mm, always >= 0
start_signal  output  1  one-cycle pulse; z_altitude_mm was just updated
outlier_count  output  8  total rejected samples, saturates at 255
primed  output  1  high once the first valid sample has been accepted

Behaviour:
- Reset (async, active-high): all of the following clear immediately, at any state.
  - Outputs: z_altitude_mm=0, start_signal=0, outlier_count=0, primed=0.
  - Internal: buffer entries, running sum, write pointer and reject_run counter cleared; state returns to WAIT.
- FSM states, one-hot: WAIT, CHECK, UPDATE, AVERAGE, EMIT.
- WAIT:
  - raw_valid=1 latches raw_range_mm into sample_latched; next state is CHECK.
  - Otherwise remain in WAIT.
- raw_valid outside WAIT is ignored: the sample is dropped silently and no counter changes.
- CHECK, evaluated in this order:
  - Invalid sample (sample < MIN_RANGE_MM or > MAX_RANGE_MM): outlier_count++ (saturating); reject_run unchanged; go to WAIT.
  - primed=0, or reject_run == MAX_REJECTS: set reprime flag; reject_run=0; go to UPDATE.
  - |sample - z_altitude_mm| > MAX_STEP_MM: outlier_count++ (saturating); reject_run++; go to WAIT.
  - Otherwise: reject_run=0; go to UPDATE.
- UPDATE:
  - With reprime: every buffer entry = sample; sum = sample << AVG_LOG2; write pointer = 0; primed=1.
  - Without reprime: sum = sum - buf[wr_ptr] + sample; buf[wr_ptr] = sample; wr_ptr increments and wraps modulo 2^AVG_LOG2.
  - Next state: AVERAGE.
- AVERAGE: avg = sum >> AVG_LOG2 (truncating); z_altitude_mm loads avg at the exit edge; next state EMIT.
- EMIT: start_signal=1 for exactly this cycle; next state WAIT.
- Arithmetic widths:
  - sum is unsigned, WIDTH+AVG_LOG2 bits, and cannot overflow.
  - Step comparison uses signed WIDTH+1 bit arithmetic.
  - z_altitude_mm always holds a non-negative value <= MAX_RANGE_MM.
- Latency: raw_valid in cycle N yields start_signal high in cycle N+4, with the new z_altitude_mm stable from N+4.
  - Sample throughput is at most one per 5 cycles.
  - Rejected samples return to WAIT at N+2.
- start_signal is never high in two consecutive cycles.
- z_altitude_mm changes only at the EMIT entry edge or on reset.

Test Plan:
1. Reset, then raw_valid with 1000 in cycle N -> start_signal high in N+4 only; z_altitude_mm=1000; primed=1; outlier_count=0.
2. After test 1, feed 1100, 1200, 1300 (spaced >= 5 cycles apart) -> z_altitude_mm = 1025, 1075, 1150, each with one start_signal pulse.
3. Primed at 1000, feed 2000 -> no start_signal; z_altitude_mm stays 1000; outlier_count=1.
4. Primed at 1000, feed 2000 four times -> first three rejected (outlier_count=3); fourth re-primes and gives z_altitude_mm=2000 with a pulse; a following 2010 gives 2002.
5. Feed 0, then 12000 -> both rejected; outlier_count +2; reject_run unaffected; no pulse.
6. Assert raw_valid in the CHECK cycle -> that sample is ignored. Then assert reset during UPDATE -> all outputs are 0 immediately; the next sample of 800 re-primes and gives z_altitude_mm=800.
